dct_transpose_buf: RTL and testbench

Parametrised ping-pong transpose buffer between the row and column 1-D DCT passes of the 2-D DCT datapath. It accepts one N×N block of row-pass coefficients in row-major raster order and re-emits it in column-major order, or in row-major order when transposition is off. Two banks let one block be written while the previous one is read, sustaining one sample per clock on both sides. Both sides use valid/ready handshakes.

---
 rtl/dct_pkg.sv | 13 +
 rtl/dct_tbuf_bank.sv | 26 ++
 rtl/dct_transpose_buf.sv | 148 ++++++++++++++
 tb/tb_dct_transpose_buf.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/dct_pkg.sv
// Shared constants and helpers for the 2-D DCT datapath.
package dct_pkg;

    localparam int DCT_N     = 8;
    localparam int DCT_ROW_W = 11;

    typedef logic bank_t;

    function automatic int idx_width(input int n);
        return $clog2(n * n);
    endfunction

endpackage

// File: rtl/dct_tbuf_bank.sv
// One N*N x DW storage bank: synchronous write, asynchronous read, no reset on contents.
module dct_tbuf_bank
    import dct_pkg::*;
#(
    parameter int N  = DCT_N,
    parameter int DW = DCT_ROW_W
) (
    input  logic                    clk,
    input  logic                    we_i,
    input  logic [idx_width(N)-1:0] waddr_i,
    input  logic [DW-1:0]           wdata_i,
    input  logic [idx_width(N)-1:0] raddr_i,
    output logic [DW-1:0]           rdata_o
);

    logic [DW-1:0] mem_q [N*N];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/dct_transpose_buf.sv
// Ping-pong transpose buffer between the row and column DCT passes.
// Accepts row-major blocks and emits them column-major (or row-major) with valid/ready on both sides.
module dct_transpose_buf
    import dct_pkg::*;
#(
    parameter int N  = DCT_N,
    parameter int DW = DCT_ROW_W
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid_i,
    input  logic [DW-1:0] in_data_i,
    output logic          in_ready_o,
    input  logic          transpose_i,
    output logic          out_valid_o,
    output logic [DW-1:0] out_data_o,
    output logic          out_last_o,
    input  logic          out_ready_i
);

    localparam int AW = idx_width(N);
    localparam int CW = $clog2(N);
    localparam logic [AW-1:0] LAST_IDX = AW'(N * N - 1);
    localparam logic [CW-1:0] LAST_RC  = CW'(N - 1);

    logic [1:0]    full_q, full_d;
    logic [1:0]    mode_q, mode_d;
    bank_t         wbank_q, wbank_d;
    bank_t         rbank_q, rbank_d;
    logic [AW-1:0] widx_q, widx_d;
    logic [CW-1:0] r_q, r_d;
    logic [CW-1:0] c_q, c_d;
    logic          out_valid_q, out_valid_d;
    logic          out_last_q, out_last_d;
    logic [DW-1:0] out_data_q, out_data_d;

    logic          wr_acc, wr_done, rd_load, rd_last;
    logic [AW-1:0] raddr;
    logic [DW-1:0] rdata [2];

    assign in_ready_o = !full_q[wbank_q];
    assign wr_acc     = in_valid_i && in_ready_o;
    assign wr_done    = wr_acc && (widx_q == LAST_IDX);
    assign rd_load    = full_q[rbank_q] && (!out_valid_q || out_ready_i);
    // Final sample sits at (N-1, N-1) in either scan order.
    assign rd_last    = rd_load && (r_q == LAST_RC) && (c_q == LAST_RC);
    assign raddr      = {r_q, c_q};

    for (genvar gi = 0; gi < 2; gi++) begin : g_bank
        dct_tbuf_bank #(
            .N  (N),
            .DW (DW)
        ) u_bank (
            .clk     (clk),
            .we_i    (wr_acc && (wbank_q == bank_t'(gi))),
            .waddr_i (widx_q),
            .wdata_i (in_data_i),
            .raddr_i (raddr),
            .rdata_o (rdata[gi])
        );
    end

    always_comb begin
        full_d      = full_q;
        mode_d      = mode_q;
        wbank_d     = wbank_q;
        rbank_d     = rbank_q;
        widx_d      = widx_q;
        r_d         = r_q;
        c_d         = c_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_data_d  = out_data_q;

        if (wr_acc) begin
            widx_d = widx_q + 1'b1;
            // Readout order travels with the bank, captured on its first sample.
            if (widx_q == '0) begin
                mode_d[wbank_q] = transpose_i;
            end
            if (wr_done) begin
                widx_d          = '0;
                full_d[wbank_q] = 1'b1;
                wbank_d         = ~wbank_q;
            end
        end

        if (rd_load) begin
            out_valid_d = 1'b1;
            out_data_d  = rdata[rbank_q];
            out_last_d  = rd_last;
            if (rd_last) begin
                r_d             = '0;
                c_d             = '0;
                full_d[rbank_q] = 1'b0;
                rbank_d         = ~rbank_q;
            end else if (mode_q[rbank_q]) begin
                if (r_q == LAST_RC) begin
                    r_d = '0;
                    c_d = c_q + 1'b1;
                end else begin
                    r_d = r_q + 1'b1;
                end
            end else begin
                if (c_q == LAST_RC) begin
                    c_d = '0;
                    r_d = r_q + 1'b1;
                end else begin
                    c_d = c_q + 1'b1;
                end
            end
        end else if (out_ready_i) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q      <= '0;
            mode_q      <= '0;
            wbank_q     <= 1'b0;
            rbank_q     <= 1'b0;
            widx_q      <= '0;
            r_q         <= '0;
            c_q         <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
        end else begin
            full_q      <= full_d;
            mode_q      <= mode_d;
            wbank_q     <= wbank_d;
            rbank_q     <= rbank_d;
            widx_q      <= widx_d;
            r_q         <= r_d;
            c_q         <= c_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_last_o  = out_last_q;
    assign out_data_o  = out_data_q;

endmodule

// File: tb/tb_dct_transpose_buf.sv
// Randomised bench for dct_transpose_buf against a block-level reorder model.
module tb_dct_transpose_buf;

    localparam int N  = 8;
    localparam int DW = 11;
    localparam int NN = N * N;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_ready;
    logic          transpose = 1'b1;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          out_ready = 1'b0;

    always #5 clk = ~clk;

    dct_transpose_buf #(
        .N  (N),
        .DW (DW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (in_valid),
        .in_data_i   (in_data),
        .in_ready_o  (in_ready),
        .transpose_i (transpose),
        .out_valid_o (out_valid),
        .out_data_o  (out_data),
        .out_last_o  (out_last),
        .out_ready_i (out_ready)
    );

    int n_vec = 0;
    int n_err = 0;

    int            in_q[$];
    logic [DW-1:0] cur_blk[$];
    logic          cur_mode;
    int            exp_d[$];
    bit            exp_l[$];

    int            acc_cnt = 0;
    int            out_cnt = 0;
    int            blk_cnt = 0;
    int            toggle_at = -1;
    int            cyc = 0;
    int            lat_edge = -1;
    bit            lat_armed = 0;
    int            last_hs = 0;
    bit            prev_hold = 0;
    logic [DW-1:0] prev_data = '0;
    logic          prev_last = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Completed block -> expected output stream in the order its first sample selected.
    task automatic model_accept(input logic [DW-1:0] d, input logic t);
        int idx;
        cur_blk.push_back(d);
        if (cur_blk.size() == 1) cur_mode = t;
        if (cur_blk.size() == NN) begin
            for (int k = 0; k < NN; k++) begin
                idx = cur_mode ? (k % N) * N + k / N : k;
                exp_d.push_back(int'(cur_blk[idx]));
                exp_l.push_back(k == NN - 1);
            end
            cur_blk.delete();
            if (lat_edge < 0) lat_edge = cyc + 1;
        end
    endtask

    task automatic observe();
        int  ed;
        bit  el;
        if (prev_hold) begin
            check("hold_valid", 32'(out_valid), 1);
            check("hold_data", 32'(out_data), 32'(prev_data));
            check("hold_last", 32'(out_last), 32'(prev_last));
        end
        if (out_valid && lat_armed) begin
            check("latency", cyc, lat_edge + 1);
            lat_armed = 0;
        end
        if (out_valid && out_ready) begin
            if (exp_d.size() == 0) begin
                check("unexpected_out", 1, 0);
            end else begin
                ed = exp_d.pop_front();
                el = exp_l.pop_front();
                check("data", 32'(out_data), ed);
                check("last", 32'(out_last), 32'(el));
                out_cnt++;
                last_hs = cyc;
                if (el) begin
                    blk_cnt++;
                    $display("block %0d delivered at cycle %0d", blk_cnt, cyc);
                end
                if (out_cnt == toggle_at) transpose = ~transpose;
            end
        end
        if (in_valid && in_ready) begin
            model_accept(in_data, transpose);
            void'(in_q.pop_front());
            acc_cnt++;
        end
        prev_hold = out_valid && !out_ready;
        prev_data = out_data;
        prev_last = out_last;
    endtask

    // out_mode: 0 = ready held high, 1 = random backpressure, 2 = ready held low
    task automatic run(input int max_cyc, input int out_mode, input bit rnd_in, input bit must_finish);
        bit done = 0;
        for (int i = 0; i < max_cyc; i++) begin
            in_valid  = (in_q.size() > 0) && (!rnd_in || $urandom_range(0, 3) != 0);
            in_data   = (in_q.size() > 0) ? DW'(in_q[0]) : DW'($urandom);
            out_ready = (out_mode == 0) ? 1'b1 : (out_mode == 1) ? ($urandom_range(0, 2) != 0) : 1'b0;
            @(negedge clk);
            observe();
            done = (in_q.size() == 0) && (exp_d.size() == 0) && !out_valid;
            @(posedge clk);
            cyc++;
            #1;
            if (must_finish && done) break;
        end
        in_valid = 1'b0;
        if (must_finish && !done) check("timeout", 0, 1);
    endtask

    task automatic push_block(input bit ramp);
        for (int k = 0; k < NN; k++) in_q.push_back(ramp ? k : int'($urandom_range(0, (1 << DW) - 1)));
    endtask

    initial begin
        int start, acc0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_data", 32'(out_data), 0);
        check("rst_out_last", 32'(out_last), 0);
        rst_n = 1'b1;

        // Ramp block, column-major readout, with startup latency
        transpose = 1'b1;
        push_block(1);
        lat_edge  = -1;
        lat_armed = 1;
        run(300, 0, 0, 1);

        // Ramp block, row-major readout
        transpose = 1'b0;
        push_block(1);
        run(300, 0, 0, 1);

        // Three back-to-back blocks streaming with no bubbles
        transpose = 1'($urandom);
        repeat (3) push_block(0);
        start = cyc;
        run(600, 0, 0, 1);
        check("thruput", last_hs - start, 4 * NN);

        // Both banks fill while downstream stalls, then drain in order
        transpose = 1'b1;
        repeat (3) push_block(0);
        acc0 = acc_cnt;
        run(200, 2, 0, 0);
        check("stall_accepts", acc_cnt - acc0, 2 * NN);
        check("stall_in_ready", 32'(in_ready), 0);
        run(2000, 0, 0, 1);

        // Random handshakes on both sides
        transpose = 1'($urandom);
        push_block(0);
        run(3000, 1, 1, 1);
        transpose = 1'($urandom);
        repeat (2) push_block(0);
        run(4000, 1, 1, 1);

        // Mode change mid-read affects only the following block
        transpose = 1'b1;
        push_block(0);
        run(70, 2, 0, 0);
        toggle_at = out_cnt + 20;
        run(500, 0, 0, 1);
        toggle_at = -1;
        push_block(0);
        run(500, 0, 0, 1);

        // Reset in the middle of a block
        transpose = 1'b0;
        for (int k = 0; k < 30; k++) in_q.push_back(k + 100);
        run(100, 0, 0, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_in_ready", 32'(in_ready), 1);
        check("mid_rst_out_valid", 32'(out_valid), 0);
        check("mid_rst_out_data", 32'(out_data), 0);
        check("mid_rst_out_last", 32'(out_last), 0);
        cur_blk.delete();
        exp_d.delete();
        exp_l.delete();
        prev_hold = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        cyc++;
        #1;
        transpose = 1'b1;
        push_block(0);
        run(500, 1, 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
